// File: rtl/present80_pkg.sv
// Shared constants, S-box tables, FSM encoding and layer helpers for the PRESENT-80 decryptor.
package present80_pkg;

   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 80;
   localparam logic [4:0] ROUNDS = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_KEYGEN = 2'd1,
      ST_ROUND  = 2'd2,
      ST_FINAL  = 2'd3
   } state_t;

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam logic [3:0] INV_SBOX [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   // Forward pLayer moves bit i to 16*i mod 63, so the inverse gathers from there.
   function automatic logic [BLOCK_W-1:0] inv_player(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] o;
      o = '0;
      for (int i = 0; i < 63; i++) begin
         o[i] = s[(i * 16) % 63];
      end
      o[63] = s[63];
      return o;
   endfunction

   function automatic logic [BLOCK_W-1:0] inv_slayer(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[i*4 +: 4] = INV_SBOX[s[i*4 +: 4]];
      end
      return o;
   endfunction

endpackage

// File: rtl/present80_key_sched.sv
// Combinational PRESENT-80 key update, forward (inv=0) or inverse (inv=1), for round counter rc.
module present80_key_sched
   import present80_pkg::*;
(
   input  logic [KEY_W-1:0] key,
   input  logic [4:0]       rc,
   input  logic             inv,
   output logic [KEY_W-1:0] next_key
);

   logic [KEY_W-1:0] fwd;
   logic [KEY_W-1:0] bwd_pre;
   logic [KEY_W-1:0] bwd;

   always_comb begin
      fwd          = {key[18:0], key[79:19]};
      fwd[79:76]   = SBOX[fwd[79:76]];
      fwd[19:15]   = fwd[19:15] ^ rc;

      // Undo the forward steps in reverse order: counter XOR, S-box, then rotate back.
      bwd_pre        = key;
      bwd_pre[19:15] = bwd_pre[19:15] ^ rc;
      bwd_pre[79:76] = INV_SBOX[bwd_pre[79:76]];
      bwd            = {bwd_pre[60:0], bwd_pre[79:61]};

      next_key = inv ? bwd : fwd;
   end

endmodule

// File: rtl/present80_dec.sv
// Iterative PRESENT-80 decryptor: derive K32 forward, then peel rounds back to K1.
// Optional key cache enabled by defining PRESENT80_DEC_KEYCACHE_EN.
module present80_dec
   import present80_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [BLOCK_W-1:0] indata,
   input  logic [KEY_W-1:0]   key,
   output logic [BLOCK_W-1:0] outdata,
   output logic               done,
   output logic               busy
);

   state_t             fsm;
   logic [4:0]         rc;
   logic [BLOCK_W-1:0] st;
   logic [KEY_W-1:0]   kreg;
   logic [KEY_W-1:0]   ks_out;
   logic               ks_inv;

   assign ks_inv = (fsm == ST_ROUND);
   assign busy   = (fsm != ST_IDLE);

   present80_key_sched u_key_sched (
      .key      (kreg),
      .rc       (rc),
      .inv      (ks_inv),
      .next_key (ks_out)
   );

`ifdef PRESENT80_DEC_KEYCACHE_EN
   logic [KEY_W-1:0] cache_ukey;
   logic [KEY_W-1:0] cache_k32;
   logic             cache_valid;
   logic             cache_hit;

   assign cache_hit = cache_valid && (key == cache_ukey);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm     <= ST_IDLE;
         rc      <= '0;
         st      <= '0;
         kreg    <= '0;
         outdata <= '0;
         done    <= 1'b0;
`ifdef PRESENT80_DEC_KEYCACHE_EN
         cache_ukey  <= '0;
         cache_k32   <= '0;
         cache_valid <= 1'b0;
`endif
      end else if (load) begin
         st   <= indata;
         done <= 1'b0;
`ifdef PRESENT80_DEC_KEYCACHE_EN
         if (cache_hit) begin
            kreg <= cache_k32;
            rc   <= ROUNDS;
            fsm  <= ST_ROUND;
         end else begin
            // The user key is remembered now; the entry becomes valid once K32 exists.
            kreg        <= key;
            rc          <= 5'd1;
            fsm         <= ST_KEYGEN;
            cache_ukey  <= key;
            cache_valid <= 1'b0;
         end
`else
         kreg <= key;
         rc   <= 5'd1;
         fsm  <= ST_KEYGEN;
`endif
      end else begin
         case (fsm)
            ST_KEYGEN: begin
               kreg <= ks_out;
               if (rc == ROUNDS) begin
                  fsm <= ST_ROUND;
`ifdef PRESENT80_DEC_KEYCACHE_EN
                  cache_k32   <= ks_out;
                  cache_valid <= 1'b1;
`endif
               end else begin
                  rc <= rc + 5'd1;
               end
            end
            ST_ROUND: begin
               st   <= inv_slayer(inv_player(st ^ kreg[79:16]));
               kreg <= ks_out;
               rc   <= rc - 5'd1;
               if (rc == 5'd1) begin
                  fsm <= ST_FINAL;
               end
            end
            ST_FINAL: begin
               outdata <= st ^ kreg[79:16];
               done    <= 1'b1;
               fsm     <= ST_IDLE;
            end
            default: begin
               fsm <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present80_dec.sv
// Directed bench for present80_dec: known-answer vectors, held/overlapping load, mid-run reset, key cache.
module tb_present80_dec;

   logic        clk;
   logic        reset;
   logic        load;
   logic [63:0] indata;
   logic [79:0] key;
   logic [63:0] outdata;
   logic        done;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   localparam logic [79:0] K_ZERO = 80'h0;
   localparam logic [79:0] K_ONES = {80{1'b1}};
   localparam logic [63:0] P_ZERO = 64'h0;
   localparam logic [63:0] P_ONES = {64{1'b1}};

   present80_dec dut (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .indata  (indata),
      .key     (key),
      .outdata (outdata),
      .done    (done),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: issue a one-cycle load, then count edges until done.
   task automatic run_block(input string tag, input logic [79:0] k, input logic [63:0] ct,
                            input logic [63:0] pt, input int lat);
      int n;
      bit seen;
      load   = 1'b1;
      key    = k;
      indata = ct;
      @(negedge clk);
      load = 1'b0;
      check({tag, "_busy_after_load"}, 80'(busy), 80'd1);
      check({tag, "_done_after_load"}, 80'(done), 80'd0);
      seen = 1'b0;
      n    = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (done && !seen) begin
            seen = 1'b1;
            n    = i;
            break;
         end
      end
      if (!seen) n = 999;
      check({tag, "_latency"}, 80'(n), 80'(lat));
      check({tag, "_outdata"}, 80'(outdata), 80'(pt));
      check({tag, "_busy_at_done"}, 80'(busy), 80'd0);
   endtask

   initial begin
      int lat2;
      bit spurious;

      reset  = 1'b0;
      load   = 1'b0;
      key    = '0;
      indata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outdata", 80'(outdata), 80'd0);
      check("reset_done", 80'(done), 80'd0);
      check("reset_busy", 80'(busy), 80'd0);
      @(negedge clk);
      reset = 1'b1;

      // Known answers; keys alternate so no load can hit a cached key.
      @(negedge clk);
      run_block("kat_k0_p0", K_ZERO, 64'h5579C1387B228445, P_ZERO, 63);
      @(negedge clk);
      run_block("kat_k1_p1", K_ONES, 64'h3333DCD3213210D2, P_ONES, 63);
      @(negedge clk);
      run_block("kat_k0_p1", K_ZERO, 64'hA112FFC72F68417B, P_ONES, 63);
      @(negedge clk);
      run_block("kat_k1_p0", K_ONES, 64'hE72C46C0F5945049, P_ZERO, 63);

      // Load held for 5 edges, then a second load at ROUND cycle 10.
      @(negedge clk);
      load   = 1'b1;
      key    = K_ZERO;
      indata = 64'hA112FFC72F68417B;
      repeat (5) @(negedge clk);
      load = 1'b0;
      repeat (40) @(negedge clk);
      check("held_busy_in_round", 80'(busy), 80'd1);
      check("held_done_low", 80'(done), 80'd0);
      check("held_outdata_kept", 80'(outdata), 80'(P_ZERO));
      run_block("held_second", K_ONES, 64'h3333DCD3213210D2, P_ONES, 63);

      // Reset at KEYGEN cycle 20 aborts the block.
      @(negedge clk);
      load   = 1'b1;
      key    = K_ZERO;
      indata = 64'h5579C1387B228445;
      @(negedge clk);
      load = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("abort_outdata", 80'(outdata), 80'd0);
      check("abort_done", 80'(done), 80'd0);
      check("abort_busy", 80'(busy), 80'd0);
      @(negedge clk);
      reset    = 1'b1;
      spurious = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) spurious = 1'b1;
      end
      check("abort_no_done", 80'(spurious), 80'd0);

      // Same key twice: the second load reuses K32 when the cache is built in.
`ifdef PRESENT80_DEC_KEYCACHE_EN
      lat2 = 32;
`else
      lat2 = 63;
`endif
      @(negedge clk);
      run_block("cache_first", K_ZERO, 64'h5579C1387B228445, P_ZERO, 63);
      @(negedge clk);
      run_block("cache_second", K_ZERO, 64'hA112FFC72F68417B, P_ONES, lat2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/present80_dec.md
PRESENT80_DEC -- requirements
Module: present80_dec

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock (single clock domain).
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: load  input  1  capture indata/key and start decryption.
REQ-004 SHALL have: indata  input  64  ciphertext block.
REQ-005 SHALL have: key  input  80  PRESENT-80 user key (K1 source).
REQ-006 SHALL have: outdata  output  64  recovered plaintext, registered.
REQ-007 SHALL have: done  output  1  level, high while outdata holds a valid result.
REQ-008 SHALL have: busy  output  1  high during KEYGEN/ROUND/FINAL.

Function
REQ-009 SHALL implement the inverse of PRESENT-80 encryption:
- state ^= K32;
- for i=31..1: inverse pLayer, inverse S-box, state ^= K_i.
REQ-010 FSM states SHALL be IDLE, KEYGEN, ROUND, FINAL; a 5-bit round counter rc SHALL track progress.
REQ-011 load=1 at any edge, in any state, SHALL capture indata into the state register and key into the key register, set rc=1, clear done, and enter KEYGEN.
- A load held high recaptures on every edge; computation starts from the last capture.
REQ-012 KEYGEN SHALL apply the forward key update once per cycle for rc=1..31:
- rotate left 61;
- S-box on bits 79:76;
- bits 19:15 ^= rc.
After 31 cycles the key register holds K32, rc=31, and the FSM enters ROUND.
REQ-013 Each ROUND cycle SHALL update:
- state <= invS(invP(state ^ key[79:16]));
- key <= inverse update: bits 19:15 ^= rc, invS on bits 79:76, rotate right 61;
- rc decrements.
ROUND SHALL last 31 cycles, leaving key = K1.
REQ-014 FINAL SHALL load outdata <= state ^ key[79:16], set done=1, and return to IDLE.
REQ-015 Latency: done SHALL rise on the 63rd rising edge after the last edge sampling load=1.
REQ-016 outdata SHALL hold its previous value until FINAL, and SHALL hold the new value until the next FINAL.
REQ-017 busy SHALL be 1 exactly when the FSM is in KEYGEN, ROUND or FINAL.
REQ-018 rc arithmetic SHALL be 5-bit unsigned; the values 0 and 32 SHALL never be used in an XOR.

Reset
REQ-019 reset=0 SHALL asynchronously force: outdata=0, done=0, busy=0, FSM=IDLE, rc=0, state and key registers=0.
REQ-020 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow deassertion without a new load.

Configuration
REQ-021 Macro PRESENT80_DEC_KEYCACHE_EN, when defined, SHALL add an 80-bit cached user key, a 80-bit cached K32, and a cache-valid flag.
- The cache is written at the KEYGEN to ROUND transition.
- A load whose key equals the valid cached key SHALL load K32 directly, set rc=31, and enter ROUND, giving a latency of 32 edges.
- The cache-valid flag SHALL be cleared by reset.
REQ-022 Without PRESENT80_DEC_KEYCACHE_EN, every load SHALL take the full 63-cycle path and no cache registers SHALL exist.

Structure
REQ-023 Package present80_pkg SHALL hold:
- the forward and inverse S-box tables;
- the ROUNDS=31 constant;
- the FSM state encoding;
- the widths 64 and 80.
REQ-024 A combinational sub-module present80_key_sched SHALL provide both the forward and inverse key updates (inputs: key and rc; a direction select); present80_dec instantiates it once.

Verification
REQ-025 Each of the following SHALL be checked at the done edge:
- key=0, indata=5579C1387B228445 -> outdata=0000000000000000, done at edge 63.
- key=FFFFFFFFFFFFFFFFFFFF, indata=E72C46C0F5945049 -> outdata=0000000000000000.
- key=0, indata=A112FFC72F68417B -> outdata=FFFFFFFFFFFFFFFF.
- key=all-ones, indata=3333DCD3213210D2 -> outdata=FFFFFFFFFFFFFFFF.
REQ-026 Load held high for 5 cycles, then a second load issued at ROUND cycle 10 -> only the second block's result appears, done at edge 63 after the second load.
REQ-027 reset pulse at KEYGEN cycle 20 -> outdata=0, done=0, busy=0 immediately.
REQ-028 With PRESENT80_DEC_KEYCACHE_EN defined, two consecutive loads with the same key -> the second gives done at edge 32 with the correct plaintext.
